// File: rtl/la_capture_sequencer.sv
// Capture sequencer for a logic analyser: fills a circular sample memory with a
// programmable number of pre-trigger samples, waits for the trigger, then fills
// the rest of the memory and stops.
module la_capture_sequencer #(
    parameter int unsigned SAMPLE_DEPTH = 4096,
    parameter int unsigned ADDR_WIDTH   = $clog2(SAMPLE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           request_start,
    input  logic [15:0]           request_stop,
    input  logic [15:0]           trigger_loc,
    input  logic                  trigger,
    output logic [15:0]           state,
    output logic [ADDR_WIDTH-1:0] read_pointer,
    output logic [ADDR_WIDTH-1:0] write_pointer,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr
);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StMove      = 3'd1,
        StInPos     = 3'd2,
        StCapturing = 3'd3,
        StCaptured  = 3'd4
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] One    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] MaxLoc = ADDR_WIDTH'(SAMPLE_DEPTH - 1);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] rp_q;
    logic [ADDR_WIDTH-1:0] wp_q;
    logic [ADDR_WIDTH-1:0] loc_q;
    logic                  start_prev_q;
    logic                  stop_prev_q;
    // Suppress edges from a request bit that was already high when reset released.
    logic                  start_blk_q;
    logic                  stop_blk_q;

    logic                  start_edge;
    logic                  stop_edge;
    logic [ADDR_WIDTH-1:0] loc_eff;
    logic [ADDR_WIDTH-1:0] wp_inc;
    logic [31:0]           loc_wide;
    logic                  unused_bits;

    assign unused_bits = ^{request_start[15:1], request_stop[15:1]};

    // Request edge detection and clamped trigger location.
    always_comb begin
        start_edge = request_start[0] & ~start_prev_q & ~start_blk_q;
        stop_edge  = request_stop[0] & ~stop_prev_q & ~stop_blk_q;
        loc_wide   = {16'd0, trigger_loc};
        if (loc_wide >= 32'(SAMPLE_DEPTH - 1)) begin
            loc_eff = MaxLoc;
        end else begin
            loc_eff = loc_wide[ADDR_WIDTH-1:0];
        end
        wp_inc = wp_q + One;
    end

    // Write enable: any filling state, except on the cycle a stop edge aborts.
    always_comb begin
        bram_we = 1'b0;
        if ((state_q == StMove) || (state_q == StInPos) || (state_q == StCapturing)) begin
            bram_we = ~stop_edge;
        end
    end

    // Sequencer FSM with pointer and request-history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rp_q         <= '0;
            wp_q         <= '0;
            loc_q        <= '0;
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
            start_blk_q  <= 1'b1;
            stop_blk_q   <= 1'b1;
        end else begin
            start_prev_q <= request_start[0];
            stop_prev_q  <= request_stop[0];
            if (!request_start[0]) begin
                start_blk_q <= 1'b0;
            end
            if (!request_stop[0]) begin
                stop_blk_q <= 1'b0;
            end
            if (stop_edge) begin
                state_q <= StIdle;
                rp_q    <= '0;
                wp_q    <= '0;
            end else begin
                unique case (state_q)
                    StIdle, StCaptured: begin
                        if (start_edge) begin
                            rp_q    <= '0;
                            wp_q    <= '0;
                            loc_q   <= loc_eff;
                            state_q <= (loc_eff != '0) ? StMove : StInPos;
                        end
                    end
                    StMove: begin
                        wp_q <= wp_inc;
                        if (wp_q == loc_q - One) begin
                            state_q <= StInPos;
                        end
                    end
                    StInPos: begin
                        wp_q <= wp_inc;
                        if (!trigger) begin
                            // Slide the pre-trigger window along with the writes.
                            rp_q <= rp_q + One;
                        end else if (wp_inc == rp_q) begin
                            state_q <= StCaptured;
                        end else begin
                            state_q <= StCapturing;
                        end
                    end
                    StCapturing: begin
                        wp_q <= wp_inc;
                        if (wp_q == rp_q - One) begin
                            state_q <= StCaptured;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign state         = {13'd0, state_q};
    assign read_pointer  = rp_q;
    assign write_pointer = wp_q;
    assign bram_addr     = wp_q;

endmodule

// File: tb/tb_la_capture_sequencer.sv
// Directed bench for la_capture_sequencer with an 8-entry sample memory.
module tb_la_capture_sequencer;

    localparam int unsigned Depth = 8;
    localparam int unsigned Aw    = 3;

    logic          clk;
    logic          rst;
    logic [15:0]   request_start;
    logic [15:0]   request_stop;
    logic [15:0]   trigger_loc;
    logic          trigger;
    logic [15:0]   state;
    logic [Aw-1:0] read_pointer;
    logic [Aw-1:0] write_pointer;
    logic          bram_we;
    logic [Aw-1:0] bram_addr;

    int checks;
    int failures;

    la_capture_sequencer #(
        .SAMPLE_DEPTH (Depth),
        .ADDR_WIDTH   (Aw)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .request_start (request_start),
        .request_stop  (request_stop),
        .trigger_loc   (trigger_loc),
        .trigger       (trigger),
        .state         (state),
        .read_pointer  (read_pointer),
        .write_pointer (write_pointer),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic start;
        logic stop;
        logic trig;
        int   loc;
        int   st;
        int   rp;
        int   wp;
        int   we;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int st, input int rp, input int wp,
                              input int we);
        chk({tag, "/state"}, int'(state), st);
        chk({tag, "/rp"}, int'(read_pointer), rp);
        chk({tag, "/wp"}, int'(write_pointer), wp);
        chk({tag, "/addr"}, int'(bram_addr), wp);
        chk({tag, "/we"}, int'(bram_we), we);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic s, input logic p, input logic t, input int l,
                                input int st, input int rp, input int wp, input int we);
        vec_t v;
        v.start = s; v.stop = p; v.trig = t; v.loc = l;
        v.st = st; v.rp = rp; v.wp = wp; v.we = we;
        return v;
    endfunction

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        request_start = 16'd0;
        request_stop  = 16'd0;
        trigger_loc   = 16'd0;
        trigger       = 1'b0;

        // Basic capture with L=3, trigger 5 cycles after start, then L=0 with trigger high.
        vecs[0]  = mk(0, 0, 0, 3, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 3, 1, 0, 0, 1);
        vecs[2]  = mk(1, 0, 0, 3, 1, 0, 1, 1);
        vecs[3]  = mk(0, 0, 0, 3, 1, 0, 2, 1);
        vecs[4]  = mk(0, 0, 0, 3, 2, 0, 3, 1);
        vecs[5]  = mk(0, 0, 0, 3, 2, 1, 4, 1);
        vecs[6]  = mk(0, 0, 1, 3, 3, 1, 5, 1);
        vecs[7]  = mk(0, 0, 0, 3, 3, 1, 6, 1);
        vecs[8]  = mk(0, 0, 1, 3, 3, 1, 7, 1);
        vecs[9]  = mk(0, 0, 0, 3, 3, 1, 0, 1);
        vecs[10] = mk(0, 0, 0, 3, 4, 1, 1, 0);
        vecs[11] = mk(0, 0, 0, 3, 4, 1, 1, 0);
        vecs[12] = mk(1, 0, 1, 0, 2, 0, 0, 1);
        vecs[13] = mk(1, 0, 1, 0, 3, 0, 1, 1);
        vecs[14] = mk(1, 0, 1, 0, 3, 0, 2, 1);
        vecs[15] = mk(1, 0, 1, 0, 3, 0, 3, 1);
        vecs[16] = mk(1, 0, 1, 0, 3, 0, 4, 1);
        vecs[17] = mk(1, 0, 1, 0, 3, 0, 5, 1);
        vecs[18] = mk(1, 0, 1, 0, 3, 0, 6, 1);
        vecs[19] = mk(1, 0, 1, 0, 3, 0, 7, 1);
        vecs[20] = mk(1, 0, 1, 0, 4, 0, 0, 0);

        step();
        step();
        check_outs("reset", 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            request_start = {15'd0, vecs[i].start};
            request_stop  = {15'd0, vecs[i].stop};
            trigger       = vecs[i].trig;
            trigger_loc   = 16'(vecs[i].loc);
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].rp, vecs[i].wp, vecs[i].we);
        end

        // Clamped location with trigger held high: 7 MOVE writes then straight to CAPTURED.
        request_start = 16'd0;
        trigger       = 1'b1;
        trigger_loc   = 16'd100;
        step();
        check_outs("clamp_hold", 4, 0, 0, 0);
        request_start = 16'd1;
        step();
        check_outs("clamp_start", 1, 0, 0, 1);
        for (int k = 1; k <= 7; k++) begin
            step();
            check_outs($sformatf("clamp_mv%0d", k), (k == 7) ? 2 : 1, 0, k, 1);
        end
        step();
        check_outs("clamp_done", 4, 0, 0, 0);

        // Long wait for trigger with L=2: the window slides and wraps.
        request_start = 16'd0;
        trigger       = 1'b0;
        trigger_loc   = 16'd2;
        step();
        request_start = 16'd1;
        step();
        check_outs("wait_start", 1, 0, 0, 1);
        step();
        check_outs("wait_mv1", 1, 0, 1, 1);
        step();
        check_outs("wait_inpos", 2, 0, 2, 1);
        for (int i = 1; i <= 20; i++) begin
            step();
            check_outs($sformatf("wait%0d", i), 2, i % 8, (2 + i) % 8, 1);
        end
        trigger = 1'b1;
        step();
        check_outs("wait_trig", 3, 4, 7, 1);
        trigger = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check_outs($sformatf("wait_cap%0d", i), 3, 4, i - 1, 1);
        end
        step();
        check_outs("wait_done", 4, 4, 4, 0);

        // Stop mid-CAPTURING with a simultaneous start edge.
        request_start = 16'd0;
        step();
        request_start = 16'd1;
        trigger_loc   = 16'd0;
        trigger       = 1'b1;
        step();
        check_outs("stop_inpos", 2, 0, 0, 1);
        request_start = 16'd0;
        step();
        check_outs("stop_cap1", 3, 0, 1, 1);
        trigger = 1'b0;
        step();
        check_outs("stop_cap2", 3, 0, 2, 1);
        request_start = 16'd1;
        request_stop  = 16'd1;
        #1;
        chk("stop_cycle_we", int'(bram_we), 0);
        step();
        check_outs("stop_idle", 0, 0, 0, 0);
        step();
        check_outs("stop_held", 0, 0, 0, 0);
        request_start = 16'd0;
        request_stop  = 16'd0;
        step();

        // Reset mid-MOVE with start held high across reset release.
        request_start = 16'd1;
        trigger_loc   = 16'd5;
        step();
        check_outs("rst_mv0", 1, 0, 0, 1);
        step();
        check_outs("rst_mv1", 1, 0, 1, 1);
        rst = 1'b1;
        step();
        check_outs("rst_asserted", 0, 0, 0, 0);
        rst = 1'b0;
        step();
        check_outs("rst_held1", 0, 0, 0, 0);
        step();
        check_outs("rst_held2", 0, 0, 0, 0);
        request_start = 16'd0;
        step();
        check_outs("rst_low", 0, 0, 0, 0);
        request_start = 16'd1;
        step();
        check_outs("rst_rearm", 1, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
